// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side signal bundle for the hazard controller: register identifiers and
// control bits in, stall/flush/forwarding controls and status out.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rs1_id;
  logic [4:0]       rs2_id;
  logic             rs1_use_id;
  logic             rs2_use_id;
  logic [4:0]       rs1_ex;
  logic [4:0]       rs2_ex;
  logic [4:0]       rd_ex;
  logic             mem_read_ex;
  logic             branch_taken_ex;
  logic [4:0]       rd_mem;
  logic             reg_write_mem;
  logic             mem_req_mem;
  logic             mem_ready;
  logic [4:0]       rd_wb;
  logic             reg_write_wb;
  logic             stall_if;
  logic             stall_id;
  logic             stall_ex;
  logic             stall_mem;
  logic             flush_id;
  logic             flush_ex;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output rs1_id, rs2_id, rs1_use_id, rs2_use_id, rs1_ex, rs2_ex, rd_ex,
           mem_read_ex, branch_taken_ex, rd_mem, reg_write_mem, mem_req_mem,
           mem_ready, rd_wb, reg_write_wb,
    input  stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
           fwd_a, fwd_b, mem_err, stall_cnt
  );

  modport slave (
    input  rs1_id, rs2_id, rs1_use_id, rs2_use_id, rs1_ex, rs2_ex, rd_ex,
           mem_read_ex, branch_taken_ex, rd_mem, reg_write_mem, mem_req_mem,
           mem_ready, rd_wb, reg_write_wb,
    output stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
           fwd_a, fwd_b, mem_err, stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: EX forwarding, load-use bubbles,
// taken-branch flushes, memory-wait stalls with timeout tracking and a stall counter.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic       mem_wait;
  logic       load_use;
  logic       stall_if, stall_id, stall_ex, stall_mem;
  logic       flush_id, flush_ex;
  logic [1:0] fwd_a, fwd_b;
  logic       any_stall;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       we_m,
    input logic [4:0] rd_w,
    input logic       we_w
  );
    if (we_m && (rd_m != 5'd0) && (rd_m == rs))
      return 2'b10;
    else if (we_w && (rd_w != 5'd0) && (rd_w == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign mem_wait = bus.mem_req_mem && !bus.mem_ready;
  assign load_use = bus.mem_read_ex && (bus.rd_ex != 5'd0) &&
                    ((bus.rs1_use_id && (bus.rs1_id == bus.rd_ex)) ||
                     (bus.rs2_use_id && (bus.rs2_id == bus.rd_ex)));

  // A memory wait freezes the whole front end, so branch and load-use actions
  // are held off until the access completes and the same instructions re-evaluate.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    fwd_a     = 2'b00;
    fwd_b     = 2'b00;
    if (!rst_n) begin
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end else begin
      fwd_a = fwd_sel(bus.rs1_ex, bus.rd_mem, bus.reg_write_mem, bus.rd_wb, bus.reg_write_wb);
      fwd_b = fwd_sel(bus.rs2_ex, bus.rd_mem, bus.reg_write_mem, bus.rd_wb, bus.reg_write_wb);
      if (mem_wait) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        stall_mem = 1'b1;
      end else if (bus.branch_taken_ex) begin
        flush_id = 1'b1;
        flush_ex = 1'b1;
      end else if (load_use) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
      end
    end
  end

  assign any_stall = stall_if | stall_id | stall_ex | stall_mem;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_err_d   = mem_err_q;
    stall_cnt_d = stall_cnt_q;
    if (any_stall && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + 1'b1;
    case (state_q)
      ST_RUN: begin
        if (mem_wait) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WC_W'(1);
        end
      end
      ST_WAIT: begin
        if (!mem_wait) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WC_W'(MEM_TIMEOUT - 1)) begin
          state_d   = ST_ERR;
          mem_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_ERR: begin
        if (!mem_wait) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_if  = stall_if;
  assign bus.stall_id  = stall_id;
  assign bus.stall_ex  = stall_ex;
  assign bus.stall_mem = stall_mem;
  assign bus.flush_id  = flush_id;
  assign bus.flush_ex  = flush_ex;
  assign bus.fwd_a     = fwd_a;
  assign bus.fwd_b     = fwd_b;
  assign bus.mem_err   = mem_err_q;
  assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: expected output vectors are queued when a
// step is driven and popped for comparison when the DUT outputs are sampled.
module tb_pipeline_hazard_ctrl;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;
  localparam int VW          = 11 + CNT_W;

  typedef struct {
    string         tag;
    logic [VW-1:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors     = 0;
  int   miscompares = 0;
  logic             exp_err;
  logic [CNT_W-1:0] exp_cnt;
  exp_t             sb[$];

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic idle();
    bus.rs1_id = 5'd0; bus.rs2_id = 5'd0; bus.rs1_use_id = 1'b0; bus.rs2_use_id = 1'b0;
    bus.rs1_ex = 5'd0; bus.rs2_ex = 5'd0; bus.rd_ex = 5'd0; bus.mem_read_ex = 1'b0;
    bus.branch_taken_ex = 1'b0; bus.rd_mem = 5'd0; bus.reg_write_mem = 1'b0;
    bus.mem_req_mem = 1'b0; bus.mem_ready = 1'b0; bus.rd_wb = 5'd0; bus.reg_write_wb = 1'b0;
  endtask

  task automatic rand_inputs();
    bus.rs1_id = 5'($urandom); bus.rs2_id = 5'($urandom);
    bus.rs1_use_id = 1'($urandom); bus.rs2_use_id = 1'($urandom);
    bus.rs1_ex = 5'($urandom); bus.rs2_ex = 5'($urandom); bus.rd_ex = 5'($urandom);
    bus.mem_read_ex = 1'($urandom); bus.branch_taken_ex = 1'($urandom);
    bus.rd_mem = 5'($urandom); bus.reg_write_mem = 1'($urandom);
    bus.mem_req_mem = 1'($urandom); bus.mem_ready = 1'($urandom);
    bus.rd_wb = 5'($urandom); bus.reg_write_wb = 1'($urandom);
  endtask

  // st = {stall_if, stall_id, stall_ex, stall_mem}, fl = {flush_id, flush_ex}.
  // set_err marks the cycle at whose closing edge mem_err must become set.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [1:0] fl,
                     input logic [1:0] fa, input logic [1:0] fb, input logic set_err);
    exp_t e, got;
    logic [VW-1:0] obs;
    e.tag = tag;
    e.v   = {st, fl, fa, fb, exp_err, exp_cnt};
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    obs = {bus.stall_if, bus.stall_id, bus.stall_ex, bus.stall_mem, bus.flush_id, bus.flush_ex,
           bus.fwd_a, bus.fwd_b, bus.mem_err, bus.stall_cnt};
    vectors++;
    assert (obs === got.v) else begin
      miscompares++;
      $error("FAIL %s: observed st=%b fl=%b fa=%b fb=%b err=%b cnt=%0d required st=%b fl=%b fa=%b fb=%b err=%b cnt=%0d",
             got.tag, obs[VW-1 -: 4], obs[VW-5 -: 2], obs[VW-7 -: 2], obs[VW-9 -: 2], obs[CNT_W], obs[CNT_W-1:0],
             got.v[VW-1 -: 4], got.v[VW-5 -: 2], got.v[VW-7 -: 2], got.v[VW-9 -: 2], got.v[CNT_W], got.v[CNT_W-1:0]);
    end
    if (!rst_n) begin
      exp_cnt = '0;
      exp_err = 1'b0;
    end else begin
      if (st != 4'b0000 && exp_cnt != {CNT_W{1'b1}})
        exp_cnt = exp_cnt + 1'b1;
      if (set_err)
        exp_err = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    exp_err = 1'b0;
    exp_cnt = '0;
    rand_inputs();
    @(posedge clk);
    #1;

    // Reset held with random inputs
    rand_inputs(); cyc("reset_0", 4'b0000, 2'b11, 2'b00, 2'b00, 1'b0);
    rand_inputs(); cyc("reset_1", 4'b0000, 2'b11, 2'b00, 2'b00, 1'b0);
    rst_n = 1'b1;
    idle(); cyc("idle", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0);

    // Forwarding
    bus.rs1_ex = 5'd5; bus.rs2_ex = 5'd9;
    bus.rd_mem = 5'd5; bus.reg_write_mem = 1'b1; bus.rd_wb = 5'd5; bus.reg_write_wb = 1'b1;
    cyc("fwd_mem_prio", 4'b0000, 2'b00, 2'b10, 2'b00, 1'b0);
    bus.reg_write_mem = 1'b0; bus.rs2_ex = 5'd5;
    cyc("fwd_wb", 4'b0000, 2'b00, 2'b01, 2'b01, 1'b0);
    bus.rs1_ex = 5'd0; bus.rd_mem = 5'd0; bus.reg_write_mem = 1'b1;
    bus.rd_wb = 5'd0; bus.rs2_ex = 5'd0;
    cyc("fwd_x0", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0);
    bus.rs2_ex = 5'd3; bus.rd_wb = 5'd3;
    cyc("fwd_b_wb_mem_x0", 4'b0000, 2'b00, 2'b00, 2'b01, 1'b0);
    idle();

    // Load-use: lw x7 in EX, add x8,x7,x1 in ID
    bus.mem_read_ex = 1'b1; bus.rd_ex = 5'd7;
    bus.rs1_id = 5'd7; bus.rs1_use_id = 1'b1; bus.rs2_id = 5'd1; bus.rs2_use_id = 1'b1;
    cyc("loaduse_rs1", 4'b1100, 2'b01, 2'b00, 2'b00, 1'b0);
    idle(); cyc("loaduse_after", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0);
    bus.mem_read_ex = 1'b1; bus.rd_ex = 5'd0; bus.rs1_id = 5'd0; bus.rs1_use_id = 1'b1;
    cyc("loaduse_rd_x0", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0);
    bus.rd_ex = 5'd12; bus.rs1_id = 5'd2; bus.rs2_id = 5'd12; bus.rs2_use_id = 1'b0;
    cyc("loaduse_rs2_unused", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0);
    bus.rs2_use_id = 1'b1;
    cyc("loaduse_rs2", 4'b1100, 2'b01, 2'b00, 2'b00, 1'b0);

    // Taken branch overrides load-use
    bus.branch_taken_ex = 1'b1;
    cyc("branch_over_lu", 4'b0000, 2'b11, 2'b00, 2'b00, 1'b0);
    idle();

    // Memory wait of 3 cycles with a pending taken branch
    bus.mem_req_mem = 1'b1; bus.branch_taken_ex = 1'b1;
    for (int i = 0; i < 3; i++) cyc($sformatf("memwait_%0d", i), 4'b1111, 2'b00, 2'b00, 2'b00, 1'b0);
    bus.mem_ready = 1'b1;
    cyc("memwait_release_branch", 4'b0000, 2'b11, 2'b00, 2'b00, 1'b0);
    idle(); bus.mem_ready = 1'b1;
    cyc("ready_without_req", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0);
    idle(); cyc("memwait_no_err", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0);

    // Timeout: mem_err rises after the 4th wait cycle
    bus.mem_req_mem = 1'b1;
    for (int i = 0; i < 6; i++)
      cyc($sformatf("timeout_wait_%0d", i), 4'b1111, 2'b00, 2'b00, 2'b00, i == MEM_TIMEOUT - 1);
    bus.mem_ready = 1'b1;
    cyc("timeout_release", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0);
    idle(); cyc("err_sticky", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0);
    rst_n = 1'b0;
    cyc("err_reset", 4'b0000, 2'b11, 2'b00, 2'b00, 1'b0);
    rst_n = 1'b1;
    cyc("err_cleared", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0);

    // Reset in the middle of a wait must not leave a partial wait count behind
    bus.mem_req_mem = 1'b1;
    for (int i = 0; i < 3; i++) cyc($sformatf("midwait_%0d", i), 4'b1111, 2'b00, 2'b00, 2'b00, 1'b0);
    rst_n = 1'b0;
    cyc("midwait_reset", 4'b0000, 2'b11, 2'b00, 2'b00, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc($sformatf("postreset_wait_%0d", i), 4'b1111, 2'b00, 2'b00, 2'b00, 1'b0);
    bus.mem_ready = 1'b1;
    cyc("postreset_release", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0);

    // Long wait: timeout again and stall_cnt saturation
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 16; i++)
      cyc($sformatf("saturate_%0d", i), 4'b1111, 2'b00, 2'b00, 2'b00, i == MEM_TIMEOUT - 1);
    idle(); cyc("saturated_hold", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
